// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch stage.
// Holds the fetch FSM state encoding, the fetch-buffer entry layout and
// the instruction size used for sequential PC advance.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  // Word index presented to instruction memory for a byte address.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry circular FIFO of {inst, pc} between instruction
// memory and the decoder. Flush empties it in one cycle; push and pop in
// the same cycle are legal even when full (the slot being freed is reused).
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  fetch_entry_t mem_r [2];
  logic         head_r;
  logic         tail_r;
  logic [1:0]   count_r;
  logic [1:0]   count_nxt_s;

  // Next occupancy from the push/pop pair; simultaneous push and pop keeps it.
  always_comb begin
    count_nxt_s = count_r;
    case ({push, pop})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and count; flush drops everything, contents are stale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      head_r   <= 1'b0;
      tail_r   <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      head_r   <= 1'b0;
      tail_r   <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[tail_r] <= push_entry;
        tail_r        <= ~tail_r;
      end
      if (pop) begin
        head_r <= ~head_r;
      end
      count_r <= count_nxt_s;
    end
  end

  assign count      = count_r;
  assign head_valid = (count_r != 2'd0);
  assign head_entry = mem_r[head_r];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the word address
// of instruction memory, captures returned words into fetch_buffer and hands
// them to the decoder over valid/ready. Redirects flush the buffer and win
// over push and pop. Fetch stops once the PC runs past IMEM_DEPTH words.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- when defined, a redirect
// with a non-zero low address pair enters TRAP instead of being aligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 1001
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fetch_halt,
  output logic        trap_o
);

  fetch_state_t state_r;
  fetch_state_t state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_nxt_s;
  logic [31:0]  pc_inc_s;
  logic [31:0]  target_s;
  logic         push_s;
  logic         pop_s;
  logic         pop_eff_s;
  logic         flush_s;
  logic [1:0]   count_s;
  logic         head_valid_s;
  fetch_entry_t head_entry_s;
  fetch_entry_t push_entry_s;

  // True when a byte address maps inside instruction memory.
  function automatic logic in_range(input logic [31:0] byte_addr);
    return word_index(byte_addr) < 32'(IMEM_DEPTH);
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_s;
  assign misalign_s = (redirect_pc[1:0] != 2'b00);
  assign target_s   = redirect_pc;
`else
  assign target_s   = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign pc_inc_s     = pc_r + INST_BYTES;
  assign pop_s        = head_valid_s & out_ready;
  assign push_entry_s = '{inst: imem_inst, pc: pc_r};

  // Next state, next PC and buffer controls; redirect overrides push and pop.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    push_s      = 1'b0;
    pop_eff_s   = 1'b0;
    flush_s     = 1'b0;
    if (redirect_valid) begin
      flush_s  = 1'b1;
      pc_nxt_s = target_s;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign_s) begin
        state_nxt_s = TRAP;
      end else if (in_range(target_s)) begin
        state_nxt_s = RUN;
      end else begin
        state_nxt_s = HALT;
      end
`else
      if (in_range(target_s)) begin
        state_nxt_s = RUN;
      end else begin
        state_nxt_s = HALT;
      end
`endif
    end else begin
      pop_eff_s = pop_s;
      case (state_r)
        RUN: begin
          if ((count_s < 2'd2) || pop_s) begin
            push_s   = 1'b1;
            pc_nxt_s = pc_inc_s;
            if (in_range(pc_inc_s)) begin
              state_nxt_s = RUN;
            end else begin
              state_nxt_s = HALT;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        HALT:    state_nxt_s = HALT;
        TRAP:    state_nxt_s = TRAP;
        default: state_nxt_s = HALT;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_eff_s),
    .flush      (flush_s),
    .push_entry (push_entry_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head_entry (head_entry_s)
  );

  assign imem_addr  = word_index(pc_r);
  assign out_valid  = head_valid_s;
  assign out_inst   = head_entry_s.inst;
  assign out_pc     = head_entry_s.pc;
  assign fetch_halt = (state_r == HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap_o     = (state_r == TRAP);
`else
  assign trap_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The driver pushes the
// expected instruction stream (every word from the fetch start point to the
// end of memory) whenever it issues a reset or redirect; the monitor pops
// and compares on every accepted handshake. Directed checks cover timing.
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 1001;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fetch_halt;
  logic        trap_o;

  logic [31:0] mem [DEPTH];
  logic [63:0] sb_q [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_delivered = 0;

  fetch_unit #(.RESET_PC(RST_PC), .IMEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_halt     (fetch_halt),
    .trap_o         (trap_o)
  );

  always #5 clk = ~clk;

  assign imem_inst = (imem_addr < DEPTH) ? mem[imem_addr[9:0]] : 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Expected stream from a fetch start point: sequential words to end of memory.
  task automatic load_stream(input logic [31:0] t);
    logic [31:0] a;
    sb_q.delete();
    n_delivered = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) return;
`endif
    a = t & 32'hFFFF_FFFC;
    for (int unsigned w = a >> 2; w < DEPTH; w++) begin
      sb_q.push_back({mem[w[9:0]], w << 2});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    sb_q.delete();
    cyc();
    rst = 1'b1;
    load_stream(RST_PC);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    load_stream(t);
  endtask

  // Monitor: every accepted, non-discarded instruction must match the stream head.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready && !redirect_valid) begin
        n_delivered++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_delivery: actual pc %h required no delivery", out_pc);
        end else begin
          e = sb_q.pop_front();
          chk("deliver_pc", out_pc, e[31:0]);
          chk("deliver_inst", out_inst, e[63:32]);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    int unsigned r;
    logic [31:0] t;
    rst = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;
    repeat (2) cyc();

    // reset state
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_halt", 32'(fetch_halt), 32'd0);
    chk("rst_trap", 32'(trap_o), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    cyc();
    rst = 1'b1;
    load_stream(RST_PC);

    // first instructions, one per cycle
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) chk("seq_addr", imem_addr, 32'(k));
      if (k > 0) begin
        chk("seq_valid", 32'(out_valid), 32'd1);
        chk("seq_pc", out_pc, 32'(4 * (k - 1)));
      end
      cyc();
    end

    // backpressure from reset
    out_ready = 1'b0;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("bp_inst", out_inst, 32'h0000_0013);
        chk("bp_pc", out_pc, 32'd0);
      end
      if (k == 5) chk("bp_addr", imem_addr, 32'd2);
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_order", out_pc, 32'(4 * k));
      cyc();
    end

    // redirect while full with a pop pending
    out_ready = 1'b0;
    repeat (2) cyc();
    out_ready = 1'b1;
    redirect(32'h0000_0040);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd_valid0", 32'(out_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'd16);
    cyc();
    @(negedge clk);
    chk("rd_valid1", 32'(out_valid), 32'd1);
    chk("rd_pc", out_pc, 32'h0000_0040);
    repeat (3) cyc();

    // fetch runs off the end of memory
    redirect((DEPTH - 4) * 4);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("halt_early", 32'(fetch_halt), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      @(negedge clk);
      chk("halt_flag", 32'(fetch_halt), (k == 4) ? 32'd1 : 32'd0);
    end
    repeat (3) cyc();
    @(negedge clk);
    chk("halt_count", 32'(n_delivered), 32'd4);
    chk("halt_drained", 32'(out_valid), 32'd0);
    chk("halt_stay", 32'(fetch_halt), 32'd1);
    cyc();
    redirect(32'h0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("resume_halt", 32'(fetch_halt), 32'd0);
    cyc();
    @(negedge clk);
    chk("resume_pc", out_pc, 32'd0);
    chk("resume_valid", 32'(out_valid), 32'd1);
    cyc();

    // reset mid-stream while full
    out_ready = 1'b0;
    repeat (3) cyc();
    apply_reset();
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_halt", 32'(fetch_halt), 32'd0);
    chk("mrst_addr", imem_addr, 32'd0);
    chk("mrst_inst", out_inst, 32'd0);
    cyc();
    out_ready = 1'b1;
    repeat (3) cyc();

    // misaligned redirect
    redirect(32'h0000_0022);
    cyc();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("trap_flag", 32'(trap_o), 32'd1);
      chk("trap_valid", 32'(out_valid), 32'd0);
      cyc();
    end
    redirect(32'h0000_0020);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("trap_clear", 32'(trap_o), 32'd0);
    cyc();
    @(negedge clk);
    chk("trap_resume_pc", out_pc, 32'h0000_0020);
`else
    @(negedge clk);
    chk("mis_trap", 32'(trap_o), 32'd0);
    chk("mis_valid0", 32'(out_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("mis_pc", out_pc, 32'h0000_0020);
    chk("mis_valid1", 32'(out_valid), 32'd1);
`endif
    cyc();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      r = $urandom_range(0, 199);
      if (!rst) begin
        rst = 1'b1;
        load_stream(RST_PC);
      end else if (r == 0) begin
        rst = 1'b0;
        sb_q.delete();
      end else if (r < 9) begin
        case ($urandom_range(0, 9))
          0:       t = $urandom;
          1:       t = (DEPTH - $urandom_range(0, 6)) * 4;
          default: t = $urandom_range(0, DEPTH - 1) * 4;
        endcase
        if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
        redirect(t);
      end
      cyc();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    if (!rst) begin
      rst = 1'b1;
      load_stream(RST_PC);
    end
    repeat (10) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
